// File: rtl/mem_lsu_master_if.sv
// Bundle of core request/response and memory-side signals for mem_lsu_master.
// Handshake: a request transfers on a rising clock edge where req_valid_i and
// req_ready_o are both high; the core holds its request fields stable while
// req_valid_i is high and req_ready_o is low. rsp_valid_o is a single-cycle
// pulse with no back-pressure, and rsp_err_o/rsp_rdata_o are qualified by it.
// dbg_state exposes the LSU FSM state for checkers.
interface mem_lsu_master_if #(
  parameter int ADDR_WIDTH = 22
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [31:0]           req_addr_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rstrb_o;
  logic [31:0]           mem_rdata_i;
  logic [3:0]            mem_wmask_o;
  logic [31:0]           mem_wdata_o;
  logic [1:0]            dbg_state;

  // LSU side
  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
           req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o,
           mem_rstrb_o, mem_wmask_o, mem_wdata_o, dbg_state
  );

  // Core and memory side
  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
           req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o,
           mem_rstrb_o, mem_wmask_o, mem_wdata_o, dbg_state
  );
endinterface

// File: rtl/mem_lsu_master.sv
// Load/store unit initiator for a byte-masked word memory.
// One outstanding request: IDLE -> ISSUE -> (load) DATA -> RESP -> IDLE,
// stores skip DATA, rejected requests go straight from IDLE to RESP.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word requests are rejected with rsp_err_o; when undefined the address
// is rounded down to the access size and the access proceeds.
module mem_lsu_master #(
  parameter int SIZE = 4 * 1024 * 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_lsu_master_if.master    bus
);
  localparam int ADDR_WIDTH = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic                  accept;
  logic                  misalign;
  logic                  illegal;
  logic                  err_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [3:0]            lane_mask;
  logic [31:0]           lane_wdata;
  logic [31:0]           shifted;
  logic [31:0]           extended;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr_i[31:ADDR_WIDTH];

  assign accept   = (state_q == IDLE) && bus.req_valid_i;
  assign illegal  = (bus.req_size_i == 2'd3);
  assign misalign = ((bus.req_size_i == 2'd1) && bus.req_addr_i[0]) ||
                    ((bus.req_size_i == 2'd2) && (bus.req_addr_i[1:0] != 2'b00));

  // Request screening and address alignment, decided before capture
  always_comb begin
    addr_d = bus.req_addr_i[ADDR_WIDTH-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    err_d  = illegal || misalign;
`else
    err_d  = illegal;
    if (misalign) begin
      if (bus.req_size_i == 2'd1) addr_d[0] = 1'b0;
      else                        addr_d[1:0] = 2'b00;
    end
`endif
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid_i) state_d = err_d ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : DATA;
      DATA:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Request capture; fields only change on an accepted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.req_we_i;
      addr_q  <= addr_d;
      size_q  <= bus.req_size_i;
      uns_q   <= bus.req_unsigned_i;
      wdata_q <= bus.req_wdata_i;
      err_q   <= err_d;
    end
  end

  // Byte lane selection for stores and right-justification for loads
  always_comb begin
    case (size_q)
      2'd0: begin
        lane_mask  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        lane_mask  = 4'b0011 << {addr_q[1], 1'b0};
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
    shifted = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    extended = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1:    extended = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  // Load result register: cleared on accept so stores and errors return 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                rdata_q <= 32'd0;
    else if (accept)          rdata_q <= 32'd0;
    else if (state_q == DATA) rdata_q <= extended;
  end

  // Outputs decoded from state and captured request only
  always_comb begin
    bus.req_ready_o = (state_q == IDLE);
    bus.mem_rstrb_o = (state_q == ISSUE) && !we_q;
    bus.mem_wmask_o = ((state_q == ISSUE) && we_q) ? lane_mask : 4'b0000;
    bus.rsp_valid_o = (state_q == RESP);
    bus.rsp_err_o   = (state_q == RESP) && err_q;
    bus.rsp_rdata_o = rdata_q;
    bus.mem_addr_o  = addr_q;
    bus.mem_wdata_o = lane_wdata;
    bus.dbg_state   = state_q;
  end
endmodule

// File: tb/tb_mem_lsu_master.sv
// Directed testbench for mem_lsu_master with a small word-memory model.
module tb_mem_lsu_master;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_lsu_master_if #(.ADDR_WIDTH(22)) bus ();

  mem_lsu_master #(.SIZE(4 * 1024 * 1024)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // memory model: read data one cycle after strobe, byte-masked writes
  logic [31:0] mem_model [0:63];
  always @(posedge clk) begin
    if (bus.mem_rstrb_o) bus.mem_rdata_i <= mem_model[bus.mem_addr_o[7:2]];
    for (int b = 0; b < 4; b++)
      if (bus.mem_wmask_o[b])
        mem_model[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
  end

  // observations from the last request
  int          o_lat;
  int          o_strb;
  logic [3:0]  o_wmask;
  logic [31:0] o_wdata;
  logic [31:0] o_rdata;
  logic [21:0] o_addr;
  logic        o_err;
  logic        o_ready_pre;
  logic        o_after_valid;
  logic        o_after_ready;

  // driver: issue one request and monitor it to its response (bounded)
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    @(negedge clk);
    o_ready_pre        = bus.req_ready_o;
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_addr_i     = addr;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_wdata_i    = wd;
    o_lat = 0; o_strb = 0; o_wmask = 4'b0; o_wdata = 32'd0;
    o_rdata = 32'd0; o_addr = 22'd0; o_err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid_i = 1'b0;
      if (bus.mem_rstrb_o) begin
        o_strb++;
        o_addr = bus.mem_addr_o;
      end
      if (bus.mem_wmask_o != 4'b0) begin
        o_wmask = bus.mem_wmask_o;
        o_wdata = bus.mem_wdata_o;
        o_addr  = bus.mem_addr_o;
      end
      if (bus.rsp_valid_o) begin
        o_lat   = k;
        o_err   = bus.rsp_err_o;
        o_rdata = bus.rsp_rdata_o;
        break;
      end
    end
    @(negedge clk);
    o_after_valid = bus.rsp_valid_o;
    o_after_ready = bus.req_ready_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = 32'd0;
    bus.req_size_i = 2'd0; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = 32'd0;
    for (int i = 0; i < 64; i++) mem_model[i] = 32'd0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", bus.req_ready_o); end
    n_cmp++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_err_o !== 1'b0) begin n_err++; $display("FAIL rst_rsp got v=%b e=%b want 0 0", bus.rsp_valid_o, bus.rsp_err_o); end
    n_cmp++; if (bus.mem_rstrb_o !== 1'b0 || bus.mem_wmask_o !== 4'b0) begin n_err++; $display("FAIL rst_strobes got r=%b m=%b want 0", bus.mem_rstrb_o, bus.mem_wmask_o); end
    n_cmp++; if (bus.rsp_rdata_o !== 32'd0 || bus.mem_addr_o !== 22'd0 || bus.mem_wdata_o !== 32'd0) begin n_err++; $display("FAIL rst_data got rd=%h a=%h wd=%h want 0", bus.rsp_rdata_o, bus.mem_addr_o, bus.mem_wdata_o); end
    n_cmp++; if (bus.dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", bus.dbg_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    n_cmp++; if (o_ready_pre !== 1'b1) begin n_err++; $display("FAIL sw_ready got %b want 1", o_ready_pre); end
    n_cmp++; if (o_lat !== 2) begin n_err++; $display("FAIL sw_latency got %0d want 2", o_lat); end
    n_cmp++; if (o_wmask !== 4'b1111 || o_addr !== 22'h10) begin n_err++; $display("FAIL sw_issue got m=%b a=%h want 1111 10", o_wmask, o_addr); end
    n_cmp++; if (o_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata got %h want deadbeef", o_wdata); end
    n_cmp++; if (o_err !== 1'b0 || o_rdata !== 32'd0 || o_strb !== 0) begin n_err++; $display("FAIL sw_rsp got e=%b rd=%h s=%0d want 0 0 0", o_err, o_rdata, o_strb); end
    n_cmp++; if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin n_err++; $display("FAIL sw_pulse got v=%b r=%b want 0 1", o_after_valid, o_after_ready); end
  endtask

  task automatic test_store_byte;
    do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000A5);
    n_cmp++; if (o_wmask !== 4'b1000) begin n_err++; $display("FAIL sb_mask got %b want 1000", o_wmask); end
    n_cmp++; if (o_wdata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_wdata got %h want a5a5a5a5", o_wdata); end
    n_cmp++; if (o_lat !== 2) begin n_err++; $display("FAIL sb_latency got %0d want 2", o_lat); end
  endtask

  task automatic test_load_byte;
    do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'd0);
    n_cmp++; if (o_rdata !== 32'hFFFFFFA5) begin n_err++; $display("FAIL lb_rdata got %h want ffffffa5", o_rdata); end
    n_cmp++; if (o_lat !== 3 || o_strb !== 1) begin n_err++; $display("FAIL lb_timing got lat=%0d s=%0d want 3 1", o_lat, o_strb); end
    n_cmp++; if (o_addr !== 22'h13) begin n_err++; $display("FAIL lb_addr got %h want 13", o_addr); end
    do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'd0);
    n_cmp++; if (o_rdata !== 32'h000000A5) begin n_err++; $display("FAIL lbu_rdata got %h want 000000a5", o_rdata); end
  endtask

  task automatic test_load_word;
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    n_cmp++; if (o_rdata !== 32'hA5ADBEEF) begin n_err++; $display("FAIL lw_rdata got %h want a5adbeef", o_rdata); end
    n_cmp++; if (o_lat !== 3 || o_strb !== 1 || o_err !== 1'b0) begin n_err++; $display("FAIL lw_timing got lat=%0d s=%0d e=%b want 3 1 0", o_lat, o_strb, o_err); end
    n_cmp++; if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin n_err++; $display("FAIL lw_pulse got v=%b r=%b want 0 1", o_after_valid, o_after_ready); end
  endtask

  task automatic test_misaligned;
    do_req(1'b0, 32'h11, 2'd2, 1'b0, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (o_lat !== 1 || o_err !== 1'b1) begin n_err++; $display("FAIL mis_lw got lat=%0d e=%b want 1 1", o_lat, o_err); end
    n_cmp++; if (o_strb !== 0 || o_rdata !== 32'd0) begin n_err++; $display("FAIL mis_lw_access got s=%0d rd=%h want 0 0", o_strb, o_rdata); end
`else
    n_cmp++; if (o_lat !== 3 || o_err !== 1'b0) begin n_err++; $display("FAIL mis_lw got lat=%0d e=%b want 3 0", o_lat, o_err); end
    n_cmp++; if (o_addr !== 22'h10 || o_rdata !== 32'hA5ADBEEF) begin n_err++; $display("FAIL mis_lw_access got a=%h rd=%h want 10 a5adbeef", o_addr, o_rdata); end
`endif
  endtask

  task automatic test_illegal_size;
    do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'd0);
    n_cmp++; if (o_lat !== 1 || o_err !== 1'b1) begin n_err++; $display("FAIL ill_ld got lat=%0d e=%b want 1 1", o_lat, o_err); end
    n_cmp++; if (o_strb !== 0 || o_rdata !== 32'd0) begin n_err++; $display("FAIL ill_ld_access got s=%0d rd=%h want 0 0", o_strb, o_rdata); end
    do_req(1'b1, 32'h10, 2'd3, 1'b0, 32'h12345678);
    n_cmp++; if (o_lat !== 1 || o_err !== 1'b1 || o_wmask !== 4'b0) begin n_err++; $display("FAIL ill_st got lat=%0d e=%b m=%b want 1 1 0000", o_lat, o_err, o_wmask); end
  endtask

  task automatic test_half;
    do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'h80010000);
    do_req(1'b0, 32'h12, 2'd1, 1'b0, 32'd0);
    n_cmp++; if (o_rdata !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_rdata got %h want ffff8001", o_rdata); end
    do_req(1'b0, 32'h12, 2'd1, 1'b1, 32'd0);
    n_cmp++; if (o_rdata !== 32'h00008001) begin n_err++; $display("FAIL lhu_rdata got %h want 00008001", o_rdata); end
    do_req(1'b0, 32'h12, 2'd0, 1'b0, 32'd0);
    n_cmp++; if (o_rdata !== 32'h00000001) begin n_err++; $display("FAIL lb12_rdata got %h want 00000001", o_rdata); end
    do_req(1'b1, 32'h16, 2'd1, 1'b0, 32'hFFFF1234);
    n_cmp++; if (o_wmask !== 4'b1100 || o_wdata !== 32'h12341234) begin n_err++; $display("FAIL sh_issue got m=%b wd=%h want 1100 12341234", o_wmask, o_wdata); end
    do_req(1'b0, 32'h14, 2'd2, 1'b0, 32'd0);
    n_cmp++; if (o_rdata !== 32'h12340000) begin n_err++; $display("FAIL lw14_rdata got %h want 12340000", o_rdata); end
  endtask

  task automatic test_reset_mid_load;
    logic seen;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 32'h10;
    bus.req_size_i = 2'd2; bus.req_unsigned_i = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.dbg_state !== 2'd2) begin n_err++; $display("FAIL mid_in_data got %0d want 2", bus.dbg_state); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst got r=%b v=%b want 1 0", bus.req_ready_o, bus.rsp_valid_o); end
    n_cmp++; if (bus.mem_rstrb_o !== 1'b0 || bus.mem_wmask_o !== 4'b0) begin n_err++; $display("FAIL mid_rst_strobes got r=%b m=%b want 0 0000", bus.mem_rstrb_o, bus.mem_wmask_o); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid_o || bus.mem_rstrb_o || bus.mem_wmask_o != 4'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_after_release got activity=%b want 0", seen); end
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b want 1", bus.req_ready_o); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte();
    test_load_word();
    test_misaligned();
    test_illegal_size();
    test_half();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
